// File: rtl/mv_pkg.sv
// rtl/mv_pkg.sv - shared constants, FSM state type and MV helper for mv_selector
package mv_pkg;

    localparam int SAD_W         = 16;
    localparam int CANDS_PER_ROW = 16;
    localparam int NUM_CAND      = 256;
    localparam int MV_W          = 5;
    localparam int MV_OFFSET     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } mv_state_e;

    // Window position 0..15 -> signed displacement -8..+7
    function automatic logic [MV_W-1:0] mv_from_pos(input logic [3:0] pos);
        return {1'b0, pos} - MV_W'(MV_OFFSET);
    endfunction

endpackage

// File: rtl/mv_row_min.sv
// rtl/mv_row_min.sv - combinational 16-input minimum tree, lowest column wins ties
//
// Ports:
//   row_keys : 16 compare keys, column c at bits [c*W +: W]
//   min_val  : smallest key in the row
//   min_col  : column of min_val (lowest column on a tie)
module mv_row_min
    import mv_pkg::*;
#(
    parameter int W = SAD_W
) (
    input  logic [CANDS_PER_ROW*W-1:0] row_keys,
    output logic [W-1:0]               min_val,
    output logic [3:0]                 min_col
);

    logic [W-1:0] v0 [16];
    logic [W-1:0] v1 [8];
    logic [W-1:0] v2 [4];
    logic [W-1:0] v3 [2];
    logic [3:0]   c0 [16];
    logic [3:0]   c1 [8];
    logic [3:0]   c2 [4];
    logic [3:0]   c3 [2];

    // The right (higher column) operand is taken only when strictly smaller,
    // so the lower column survives every tie at every level.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            v0[i] = row_keys[i*W +: W];
            c0[i] = 4'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (v0[2*i+1] < v0[2*i]) begin
                v1[i] = v0[2*i+1];
                c1[i] = c0[2*i+1];
            end else begin
                v1[i] = v0[2*i];
                c1[i] = c0[2*i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (v1[2*i+1] < v1[2*i]) begin
                v2[i] = v1[2*i+1];
                c2[i] = c1[2*i+1];
            end else begin
                v2[i] = v1[2*i];
                c2[i] = c1[2*i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (v2[2*i+1] < v2[2*i]) begin
                v3[i] = v2[2*i+1];
                c3[i] = c2[2*i+1];
            end else begin
                v3[i] = v2[2*i];
                c3[i] = c2[2*i];
            end
        end
        if (v3[1] < v3[0]) begin
            min_val = v3[1];
            min_col = c3[1];
        end else begin
            min_val = v3[0];
            min_col = c3[0];
        end
    end

endmodule

// File: rtl/mv_selector.sv
// rtl/mv_selector.sv - picks the minimum-SAD motion vector from a 16x16 window, one row per cycle
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   sad_results/sad_valid  : 256 SADs (k = row*16+col at [16k+15:16k]) and qualifier
//   sad_ready              : high in IDLE, window is accepted on sad_valid&sad_ready
//   best_sad, best_mv_x/y  : winning SAD and signed displacement (col-8, row-8)
//   mv_valid/mv_ready      : result handshake
// Build option: MV_SEL_ZERO_BIAS_EN credits the (0,0) candidate with ZERO_BIAS.
module mv_selector #(
    parameter int SAD_W     = mv_pkg::SAD_W,
    parameter int NUM_ROWS  = 16,
    parameter int ZERO_BIAS = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_ROWS*mv_pkg::CANDS_PER_ROW*SAD_W-1:0] sad_results,
    input  logic                                         sad_valid,
    output logic                                         sad_ready,
    output logic [SAD_W-1:0]                             best_sad,
    output logic [mv_pkg::MV_W-1:0]                      best_mv_x,
    output logic [mv_pkg::MV_W-1:0]                      best_mv_y,
    output logic                                         mv_valid,
    input  logic                                         mv_ready
);

    import mv_pkg::*;

    localparam int ROW_BITS = CANDS_PER_ROW * SAD_W;
    localparam int WIN_BITS = NUM_ROWS * ROW_BITS;

    mv_state_e             state_q, state_d;
    logic [3:0]            row_q, row_d;
    logic [WIN_BITS-1:0]   win_q, win_d;
    logic [SAD_W-1:0]      best_sad_q, best_sad_d;
    logic [MV_W-1:0]       mv_x_q, mv_x_d;
    logic [MV_W-1:0]       mv_y_q, mv_y_d;

    logic [ROW_BITS-1:0]   row_sads;
    logic [ROW_BITS-1:0]   row_keys;
    logic [SAD_W-1:0]      rmin_key;
    logic [3:0]            rmin_col;
    logic [SAD_W-1:0]      rmin_sad;
    logic [SAD_W-1:0]      best_key;

    assign row_sads = win_q[int'(row_q)*ROW_BITS +: ROW_BITS];

`ifdef MV_SEL_ZERO_BIAS_EN
    localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);
    logic [SAD_W-1:0] zero_sad;
    // The running best must be tracked in key space so later rows compare
    // against the biased value, while best_sad keeps the raw SAD.
    logic [SAD_W-1:0] best_key_q, best_key_d;
    assign best_key = best_key_q;
    assign zero_sad = row_sads[MV_OFFSET*SAD_W +: SAD_W];

    always_comb begin
        row_keys = row_sads;
        if (row_q == 4'(MV_OFFSET)) begin
            row_keys[MV_OFFSET*SAD_W +: SAD_W] = (zero_sad > BIAS) ? (zero_sad - BIAS) : '0;
        end
    end
`else
    assign best_key = best_sad_q;
    assign row_keys = row_sads;
`endif

    mv_row_min #(.W(SAD_W)) u_row_min (
        .row_keys (row_keys),
        .min_val  (rmin_key),
        .min_col  (rmin_col)
    );

    // Raw SAD of the row winner (differs from rmin_key only for a biased winner)
    assign rmin_sad = row_sads[int'(rmin_col)*SAD_W +: SAD_W];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        win_d      = win_q;
        best_sad_d = best_sad_q;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
`ifdef MV_SEL_ZERO_BIAS_EN
        best_key_d = best_key_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sad_valid) begin
                    win_d      = sad_results;
                    row_d      = '0;
                    best_sad_d = '1;
                    mv_x_d     = mv_from_pos(4'd0);
                    mv_y_d     = mv_from_pos(4'd0);
`ifdef MV_SEL_ZERO_BIAS_EN
                    best_key_d = '1;
`endif
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Strict compare: an equal SAD in a later row never displaces
                // the earlier (lower index) winner.
                if (rmin_key < best_key) begin
                    best_sad_d = rmin_sad;
                    mv_x_d     = mv_from_pos(rmin_col);
                    mv_y_d     = mv_from_pos(row_q);
`ifdef MV_SEL_ZERO_BIAS_EN
                    best_key_d = rmin_key;
`endif
                end
                row_d = row_q + 4'd1;
                if (row_q == 4'(NUM_ROWS-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (mv_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            best_sad_q <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
`ifdef MV_SEL_ZERO_BIAS_EN
            best_key_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            best_sad_q <= best_sad_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
`ifdef MV_SEL_ZERO_BIAS_EN
            best_key_q <= best_key_d;
`endif
        end
    end

    // Window storage needs no reset: it is always written before being scanned.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign sad_ready = (state_q == ST_IDLE);
    assign mv_valid  = (state_q == ST_DONE);
    assign best_sad  = best_sad_q;
    assign best_mv_x = mv_x_q;
    assign best_mv_y = mv_y_q;

endmodule

// File: doc/mv_selector.md
MV_SELECTOR -- requirements
Module: mv_selector

Interface
REQ-001 Parameter SAD_W, default 16: width of one unsigned SAD value.
REQ-002 Parameter NUM_ROWS, default 16: candidate rows per search window; each row holds 16 candidates.
REQ-003 Parameter ZERO_BIAS, default 16: SAD credit for the zero vector; used only under MV_SEL_ZERO_BIAS_EN.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port sad_results, input, 4096: 256 unsigned 16-bit SADs; index k = row*16+col, at bits [16k+15:16k].
REQ-007 Port sad_valid, input, 1: sad_results is valid.
REQ-008 Port sad_ready, output, 1: block accepts a window.
REQ-009 Port best_sad, output, 16: minimum SAD found.
REQ-010 Port best_mv_x, output, 5: signed two's-complement col-8, range -8..+7.
REQ-011 Port best_mv_y, output, 5: signed two's-complement row-8, range -8..+7.
REQ-012 Port mv_valid, output, 1: best_* outputs are valid.
REQ-013 Port mv_ready, input, 1: consumer accepts the result.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-015 sad_ready SHALL be high only in IDLE.
REQ-016 On an edge with sad_ready&sad_valid, the block SHALL register all 4096 bits, clear the row counter to 0, preload best_sad to 16'hFFFF with index 0, and enter SCAN.
REQ-017 In SCAN, each cycle SHALL process one row (16 candidates) through a combinational row-min tree and increment the row counter.
REQ-018 Update rule: replace best only if rowmin < best (strict); within a row, the lowest column wins ties; overall, the lowest index k wins ties.
REQ-019 After the edge that processes row 15, the FSM SHALL enter DONE and mv_valid SHALL be high; latency is 16 cycles from the accept edge to the first cycle of mv_valid.
REQ-020 In DONE, best_sad, best_mv_x and best_mv_y SHALL be held stable while mv_valid=1 and mv_ready=0.
REQ-021 On mv_valid&mv_ready, the FSM SHALL return to IDLE and mv_valid SHALL fall on the next edge; sad_ready rises in that same cycle, giving a throughput of one window per 18 cycles minimum.
REQ-022 sad_valid asserted outside IDLE SHALL be ignored, and the captured data SHALL remain unchanged.
REQ-023 If all SADs equal 16'hFFFF, the result SHALL be k=0: best_sad=16'hFFFF, mv=(-8,-8).
REQ-024 mv_x/mv_y SHALL be derived as {1'b0,col}-8 and {1'b0,row}-8 in 5-bit arithmetic.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set state=IDLE, row counter=0, mv_valid=0, best_sad=0, best_mv_x=0 and best_mv_y=0; sad_ready SHALL then be 1.
REQ-026 Reset during SCAN or DONE SHALL discard the window in progress, with no output handshake.

Configuration
REQ-027 Macro MV_SEL_ZERO_BIAS_EN defined: the candidate k=136 (row 8, col 8, mv (0,0)) SHALL be compared using max(SAD-ZERO_BIAS,0), and a win SHALL report the unbiased SAD on best_sad.
REQ-028 Macro MV_SEL_ZERO_BIAS_EN undefined: all candidates SHALL be compared on raw SAD, and ZERO_BIAS SHALL be unused.

Structure
REQ-029 Package mv_pkg SHALL hold SAD_W, CANDS_PER_ROW=16, NUM_CAND=256, MV_W=5, MV_OFFSET=8, and the FSM state enum.
REQ-030 Sub-module mv_row_min SHALL be a combinational 16-input min tree returning the min value and a 4-bit column, with lowest-column tie priority.

Verification
REQ-031 Scenario: all SADs 100 except k=37 = 5 -> best_sad=5, mv=(-3,-6), mv_valid 16 cycles after accept.
REQ-032 Scenario: k=20 and k=200 both 0, all others 50 -> k=20 wins, mv=(-4,-7).
REQ-033 Scenario: all SADs 16'hFFFF -> best_sad=16'hFFFF, mv=(-8,-8).
REQ-034 Scenario: mv_ready held low 10 cycles in DONE, with new sad_valid pulses -> outputs stable, sad_ready=0, second window accepted only after the handshake.
REQ-035 Scenario: rst asserted at SCAN row 7 -> next cycle IDLE, mv_valid=0, sad_ready=1; the following window gives a correct result.
REQ-036 Scenario: k=136 SAD=40, k=0 SAD=30, others 1000 -> macro undefined: mv=(-8,-8), best_sad=30; macro defined (ZERO_BIAS=16): mv=(0,0), best_sad=40.
